chacha_keystream_xor: RTL and testbench

- Consumer side of the ChaCha20 block core. It requests keystream blocks from `PerformQround` and serializes each 16-word block in RFC 8439 order.
- It XORs the keystream with an incoming 32-bit plaintext/ciphertext word stream, so the same block performs encryption and decryption.
- It increments the 32-bit block counter between blocks and re-arms the core until the message's last word is consumed.
- Sits between the AEAD top-level data path and the ChaCha20 core.

---
 rtl/chacha_pkg.sv | 23 ++
 rtl/chacha_keystream_xor.sv | 121 ++++++++++++
 tb/tb_chacha_keystream_xor.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared types and helpers for the ChaCha20 keystream consumer
package chacha_pkg;

    localparam int WORD_W    = 32;
    localparam int BLK_WORDS = 16;
    localparam int CTR_W     = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    // Keystream word i lives at row i/4, column i%4 of the core's state matrix.
    function automatic word_t ks_word(input word_t [3:0][3:0] matrix, input logic [3:0] idx);
        return matrix[idx[3:2]][idx[1:0]];
    endfunction

endpackage

// File: rtl/chacha_keystream_xor.sv
// rtl/chacha_keystream_xor.sv - requests ChaCha20 blocks and XORs their keystream onto a word stream
module chacha_keystream_xor
    import chacha_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CTR_W-1:0]   init_ctr,
    output logic               blk_start,
    output logic [CTR_W-1:0]   blk_ctr,
    input  logic               ks_valid,
    input  word_t [3:0][3:0]   ks_matrix,
    input  logic               in_valid,
    output logic               in_ready,
    input  word_t              in_data,
    input  logic [3:0]         in_keep,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output word_t              out_data,
    output logic [3:0]         out_keep,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               ctr_ovf
);

    state_t                    r_state;
    state_t                    w_next;
    logic [3:0]                r_idx;
    word_t [BLK_WORDS-1:0]     r_ks_buf;
    logic [CTR_W-1:0]          r_ctr;
    logic                      r_ovf;
    logic                      w_stream;
    logic                      w_xfer;
    word_t                     w_mask;

    assign w_stream = (r_state == S_STREAM);
    assign w_xfer   = w_stream && in_valid && out_ready;
    assign w_mask   = {{8{in_keep[3]}}, {8{in_keep[2]}}, {8{in_keep[1]}}, {8{in_keep[0]}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= 4'd0;
            r_ks_buf <= '0;
            r_ctr    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ctr <= init_ctr;
                        r_ovf <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (ks_valid) begin
                        for (int i = 0; i < BLK_WORDS; i++) begin
                            r_ks_buf[i] <= ks_word(ks_matrix, 4'(i));
                        end
                        r_idx <= 4'd0;
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        r_idx <= r_idx + 4'd1;
                        // Block exhausted mid-message: advance the counter for the next request.
                        if (!in_last && (r_idx == 4'(BLK_WORDS - 1))) begin
                            r_ctr <= r_ctr + CTR_W'(1);
                            if (&r_ctr) begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_REQ;
            S_REQ:    w_next = S_WAIT;
            S_WAIT:   if (ks_valid) w_next = S_STREAM;
            S_STREAM: begin
                if (w_xfer) begin
                    if (in_last) begin
                        w_next = S_DONE;
                    end else if (r_idx == 4'(BLK_WORDS - 1)) begin
                        w_next = S_REQ;
                    end
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        blk_start = (r_state == S_REQ);
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        blk_ctr   = r_ctr;
        ctr_ovf   = r_ovf;
        in_ready  = w_stream && out_ready;
        out_valid = w_stream && in_valid;
        out_data  = '0;
        out_keep  = 4'd0;
        out_last  = 1'b0;
        if (w_stream) begin
            out_data = (in_data ^ r_ks_buf[r_idx]) & w_mask;
            out_keep = in_keep;
            out_last = in_last;
        end
    end

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// tb/tb_chacha_keystream_xor.sv - self-checking bench for chacha_keystream_xor
module tb_chacha_keystream_xor;
    import chacha_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      init_ctr;
    logic             blk_start;
    logic [31:0]      blk_ctr;
    logic             ks_valid;
    word_t [3:0][3:0] ks_matrix;
    logic             in_valid;
    logic             in_ready;
    word_t            in_data;
    logic [3:0]       in_keep;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    word_t            out_data;
    logic [3:0]       out_keep;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             ctr_ovf;

    int               checks = 0;
    int               failures = 0;
    int               ks_mode = 0;
    logic [31:0]      blk_q[$];
    logic [31:0]      core_c;
    logic             force_ks = 1'b0;
    word_t            last_out;

    chacha_keystream_xor dut (
        .clk(clk), .rst(rst), .start(start), .init_ctr(init_ctr),
        .blk_start(blk_start), .blk_ctr(blk_ctr), .ks_valid(ks_valid), .ks_matrix(ks_matrix),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last), .busy(busy), .done(done), .ctr_ovf(ctr_ovf)
    );

    always #5 clk = ~clk;

    function automatic word_t ks_gen(input int mode, input logic [31:0] ctr, input int i);
        case (mode)
            0:       return 32'hA5A5A5A5;
            1:       return word_t'(i);
            2:       return 32'h0F0F0F0F;
            default: return (ctr * 32'h9E3779B9) ^ (word_t'(i) * 32'h85EBCA6B) ^ 32'h3C6EF372;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Core model: answers each block request after a random latency.
    initial begin
        ks_valid  = 1'b0;
        ks_matrix = '0;
        forever begin
            @(negedge clk);
            if (blk_start === 1'b1 || force_ks) begin
                core_c = blk_ctr;
                if (blk_start === 1'b1) blk_q.push_back(core_c);
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                for (int i = 0; i < 16; i++) ks_matrix[i / 4][i % 4] = ks_gen(ks_mode, core_c, i);
                if (!force_ks && !rst) chk("blk_ctr_stable", blk_ctr, core_c);
                ks_valid = 1'b1;
                @(posedge clk);
                #1 ks_valid = 1'b0;
            end
        end
    end

    task automatic run_msg(input int n, input int mode, input logic [31:0] init, input int bp,
                           input int dmode, input logic [3:0] lastkeep, input int abort_at);
        word_t       d[64];
        logic [3:0]  k;
        word_t       m;
        word_t       exp;
        int          j;
        int          cyc;
        int          nblk;
        logic [63:0] endc;
        ks_mode = mode;
        blk_q.delete();
        for (int i = 0; i < n; i++) begin
            case (dmode)
                0:       d[i] = 32'h0;
                1:       d[i] = $urandom;
                2:       d[i] = 32'hFFFFFFFF;
                default: d[i] = 32'h12345678;
            endcase
        end
        @(posedge clk); #1;
        start = 1'b1; init_ctr = init;
        @(posedge clk); #1;
        start = 1'b0; init_ctr = $urandom;
        @(negedge clk);
        chk("start_to_blk_start", {31'b0, blk_start}, 32'd1);
        chk("ovf_cleared_on_start", {31'b0, ctr_ovf}, 32'd0);
        @(posedge clk); #1;
        j = 0;
        cyc = 0;
        while (j < n && j != abort_at && cyc < 3000) begin
            k = (j == n - 1) ? lastkeep : 4'hF;
            in_valid = 1'b1; in_data = d[j]; in_keep = k; in_last = (j == n - 1);
            out_ready = (bp == 0) ? 1'b1 : (bp == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid) chk("in_ready_follows", {31'b0, in_ready}, {31'b0, out_ready});
            if (out_valid && out_ready) begin
                m   = {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
                exp = (d[j] ^ ks_gen(mode, init + 32'(j / 16), j % 16)) & m;
                chk($sformatf("data[%0d]", j), out_data, exp);
                chk($sformatf("keep[%0d]", j), {28'b0, out_keep}, {28'b0, k});
                chk($sformatf("last[%0d]", j), {31'b0, out_last}, {31'b0, (j == n - 1)});
                last_out = out_data;
                j++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        if (abort_at >= 0) begin
            chk("abort_reached", j, abort_at);
            return;
        end
        chk("msg_complete", j, n);
        nblk = (n + 15) / 16;
        endc = {32'b0, init} + 64'(nblk - 1);
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_in_done", {31'b0, busy}, 32'd1);
        chk("ctr_ovf", {31'b0, ctr_ovf}, {31'b0, (endc > 64'hFFFFFFFF)});
        chk("blk_count", blk_q.size(), nblk);
        for (int b = 0; b < blk_q.size(); b++) chk($sformatf("blk_ctr[%0d]", b), blk_q[b], init + 32'(b));
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("idle_after_done", {31'b0, busy}, 32'd0);
        chk("ovf_sticky", {31'b0, ctr_ovf}, {31'b0, (endc > 64'hFFFFFFFF)});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; init_ctr = '0;
        in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1; in_valid = 1'b1; in_keep = 4'hF;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_blk_start", {31'b0, blk_start}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_keep_last", {27'b0, out_keep, out_last}, 32'd0);
        chk("rst_blk_ctr", blk_ctr, 32'd0);
        chk("rst_done_ovf", {30'b0, done, ctr_ovf}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        run_msg(1, 0, 32'd1, 0, 3, 4'hF, -1);
        chk("single_word_value", last_out, 32'hB791F3DD);

        run_msg(20, 1, 32'd7, 0, 0, 4'hF, -1);

        run_msg(2, 2, $urandom, 0, 2, 4'b0011, -1);
        chk("partial_last_value", last_out, 32'h0000F0F0);

        run_msg(16, 3, $urandom, 1, 1, 4'hF, -1);

        run_msg(17, 3, 32'hFFFFFFFF, 2, 1, 4'hF, -1);

        run_msg(40, 3, 32'hFFFFFFFF, 0, 1, 4'hF, 21);
        chk("ovf_before_reset", {31'b0, ctr_ovf}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
        chk("abort_ovf", {31'b0, ctr_ovf}, 32'd0);
        force_ks = 1'b1;
        @(posedge clk); #1;
        force_ks = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("stray_ks_ignored", {30'b0, busy, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;

        for (int t = 0; t < 4; t++) begin
            run_msg($urandom_range(1, 40), 3, $urandom, 2, 1, 4'($urandom_range(1, 15)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
